// File: rtl/agent_bus_arbiter.sv
// Round-robin arbiter that hands the shared environment/pheromone bus to one ant agent at a time.
// It scans every request in one cycle and holds each grant for a length that depends on the agent's solved flag.
module agent_bus_arbiter #(
   parameter int NUM_AGENTS = 8,
   parameter int POS_ADDR   = 4,
   parameter int STEP_W     = 2,
   parameter int LEN_SEARCH = 3,
   parameter int LEN_SOLVED = 2,
   localparam int CNT_W     = $clog2((LEN_SEARCH > LEN_SOLVED) ? LEN_SEARCH : LEN_SOLVED),
   localparam int ID_W      = $clog2(NUM_AGENTS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall,
   input  logic [NUM_AGENTS-1:0]            bus_request,
   input  logic [NUM_AGENTS-1:0]            solved,
   input  logic [NUM_AGENTS*2*POS_ADDR-1:0] poses_now,
   input  logic [NUM_AGENTS*STEP_W-1:0]     steps,
   output logic [NUM_AGENTS-1:0]            bus_av,
   output logic [ID_W-1:0]                  grant_id,
   output logic [2*POS_ADDR-1:0]            pos_active,
   output logic [STEP_W-1:0]                step_active,
   output logic                             solved_out,
   output logic [CNT_W-1:0]                 grant_count,
   output logic                             ph_wr
);

   localparam int PW = 2 * POS_ADDR;
   localparam int SW = ID_W + 1;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   localparam logic [CNT_W-1:0] CNT_SEARCH = CNT_W'(LEN_SEARCH - 1);
   localparam logic [CNT_W-1:0] CNT_SOLVED = CNT_W'(LEN_SOLVED - 1);
   localparam logic [SW-1:0]    N_SW       = SW'(NUM_AGENTS);
   localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_AGENTS - 1);

   logic                  r_state;
   logic [ID_W-1:0]       r_ptr;
   logic [NUM_AGENTS-1:0] r_bus_av;
   logic [ID_W-1:0]       r_grant_id;
   logic [PW-1:0]         r_pos;
   logic [STEP_W-1:0]     r_step;
   logic                  r_solved;
   logic [CNT_W-1:0]      r_grant_count;

   logic                  w_found;
   logic [ID_W-1:0]       w_win;
   logic [PW-1:0]         w_pos;
   logic [STEP_W-1:0]     w_step;
   logic                  w_solv;
   logic [CNT_W-1:0]      w_len_m1;

   // Walk the requests starting at the pointer and wrapping, so the first hit is the round-robin winner.
   always_comb begin
      logic [SW-1:0] v_idx;
      v_idx   = '0;
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NUM_AGENTS; i++) begin
         v_idx = {1'b0, r_ptr} + SW'(i);
         if (v_idx >= N_SW) begin
            v_idx = v_idx - N_SW;
         end
         if (!w_found && bus_request[v_idx[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = v_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      w_pos  = '0;
      w_step = '0;
      w_solv = 1'b0;
      for (int j = 0; j < NUM_AGENTS; j++) begin
         if (w_win == ID_W'(j)) begin
            w_pos  = poses_now[j*PW +: PW];
            w_step = steps[j*STEP_W +: STEP_W];
            w_solv = solved[j];
         end
      end
      w_len_m1 = w_solv ? CNT_SOLVED : CNT_SEARCH;
   end

   // Inputs are only sampled in IDLE; once granted, the agent keeps the bus for its full length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_ptr         <= '0;
         r_bus_av      <= '0;
         r_grant_id    <= '0;
         r_pos         <= '0;
         r_step        <= '0;
         r_solved      <= 1'b0;
         r_grant_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!stall && w_found) begin
                  r_state       <= ST_GRANT;
                  r_bus_av      <= NUM_AGENTS'(1) << w_win;
                  r_grant_id    <= w_win;
                  r_pos         <= w_pos;
                  r_step        <= w_step;
                  r_solved      <= w_solv;
                  r_grant_count <= w_len_m1;
               end
            end
            default: begin
               if (r_grant_count == '0) begin
                  r_state  <= ST_IDLE;
                  r_bus_av <= '0;
                  r_ptr    <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
               end else begin
                  r_grant_count <= r_grant_count - 1'b1;
               end
            end
         endcase
      end
   end

   assign bus_av      = r_bus_av;
   assign grant_id    = r_grant_id;
   assign pos_active  = r_pos;
   assign step_active = r_step;
   assign solved_out  = r_solved;
   assign grant_count = r_grant_count;
   assign ph_wr       = (r_state == ST_GRANT) && (r_grant_count == '0);

endmodule
